// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory controller.
//   - access size codes as carried on cpu_size / dma_size
//   - controller FSM state encoding
//   - requester port indices used by the arbiter and transaction registers
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for the data-memory controller.
// Ports:
//   chk_size, chk_addr  in  size and addr[1:0] of the request being granted
//   misaligned          out 1 = misaligned access or reserved size
//   size, addr, zext    in  latched transaction size, addr[1:0], zero-extend flag
//   wdata               in  latched right-justified store data
//   rdata               in  word currently on ram_rdata
//   store_word          out word to write: rdata with the addressed lane replaced
//                           (or wdata itself for a word store)
//   load_data           out addressed lane of rdata, sign- or zero-extended
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr,
  output logic        misaligned,
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Alignment check on the request that the arbiter is about to grant, so
  // the error can be latched together with the rest of the transaction.
  always_comb begin
    misaligned = 1'b1;
    case (chk_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = chk_addr[0];
      SZ_WORD: misaligned = (chk_addr != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Store merge: start from the word read back during RD and overwrite only
  // the addressed little-endian lane.
  always_comb begin
    store_word = rdata;
    case (size)
      SZ_BYTE: store_word[{addr, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_word = wdata;
      default: store_word = rdata;
    endcase
  end

  // Load path: pick the addressed lane and extend it; words ignore zext.
  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = zext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = zext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: shares one single-port data RAM between the CPU MEM stage
// (port 0) and a DMA/debug port (port 1) with round-robin arbitration,
// alignment checking, read-modify-write sub-word stores and extended loads.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_*/dma_* req,we,size,zext,
//               addr,wdata           request fields, held until ack
//   cpu_*/dma_* ack,err,rdata        one-cycle completion, error flag, load data
//   ram_ena, ram_wena, ram_addr,
//   ram_wdata                        RAM control (decoded from state)
//   ram_rdata                        RAM read word, valid the cycle after a read
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_zext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic              dma_zext,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [31:0]       dma_rdata,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state;
  logic              last;
  logic              t_port;
  logic              t_we;
  logic              t_zext;
  logic              t_err;
  logic [1:0]        t_size;
  logic [ADDR_W+1:0] t_addr;
  logic [31:0]       t_wdata;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dma_rdata_q;

  logic              gnt;
  logic              sel_we;
  logic              sel_zext;
  logic [1:0]        sel_size;
  logic [ADDR_W+1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_mis;
  logic [31:0]       store_word;
  logic [31:0]       load_data;
  logic              in_done;
  logic              load_done;

  // Address bits above the RAM window are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dma_addr[31:ADDR_W+2]};

  // Round-robin pick: on a tie the port that was not granted last wins,
  // otherwise whichever port is requesting. The winner's fields are muxed
  // so the alignment check sees exactly what will be latched.
  always_comb begin
    gnt = (cpu_req && dma_req) ? ~last : dma_req;
    if (gnt == P_DMA) begin
      sel_we    = dma_we;
      sel_zext  = dma_zext;
      sel_size  = dma_size;
      sel_addr  = dma_addr[ADDR_W+1:0];
      sel_wdata = dma_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_zext  = cpu_zext;
      sel_size  = cpu_size;
      sel_addr  = cpu_addr[ADDR_W+1:0];
      sel_wdata = cpu_wdata;
    end
  end

  dmem_lane u_lane (
    .chk_size   (sel_size),
    .chk_addr   (sel_addr[1:0]),
    .misaligned (sel_mis),
    .size       (t_size),
    .addr       (t_addr[1:0]),
    .zext       (t_zext),
    .wdata      (t_wdata),
    .rdata      (ram_rdata),
    .store_word (store_word),
    .load_data  (load_data)
  );

  // Controller FSM, arbiter pointer and transaction registers. Errored
  // requests jump straight to DONE so they never touch the RAM; sub-word
  // stores and loads go through RD, word stores skip straight to WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= P_DMA;
      t_port      <= P_CPU;
      t_we        <= 1'b0;
      t_zext      <= 1'b0;
      t_err       <= 1'b0;
      t_size      <= SZ_BYTE;
      t_addr      <= '0;
      t_wdata     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            last    <= gnt;
            t_port  <= gnt;
            t_we    <= sel_we;
            t_zext  <= sel_zext;
            t_size  <= sel_size;
            t_addr  <= sel_addr;
            t_wdata <= sel_wdata;
            t_err   <= sel_mis;
            if (sel_mis)                              state <= DONE;
            else if (!sel_we || sel_size != SZ_WORD)  state <= RD;
            else                                      state <= WR;
          end
        end
        RD:   state <= t_we ? WR : DONE;
        WR:   state <= DONE;
        DONE: begin
          if (load_done && t_port == P_CPU) cpu_rdata_q <= load_data;
          if (load_done && t_port == P_DMA) dma_rdata_q <= load_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM-side outputs come purely from state and transaction registers.
  // During WR, ram_rdata still carries the word read in RD, so the merged
  // store word can be formed directly from it.
  assign ram_ena   = (state == RD) || (state == WR);
  assign ram_wena  = (state == WR);
  assign ram_addr  = t_addr[ADDR_W+1:2];
  assign ram_wdata = (state == WR) ? store_word : '0;

  // Completion side. Load data is only on ram_rdata during DONE, so it is
  // forwarded in that cycle and captured to hold it until the next load.
  assign in_done   = (state == DONE);
  assign load_done = in_done && !t_we && !t_err;
  assign cpu_ack   = in_done && (t_port == P_CPU);
  assign dma_ack   = in_done && (t_port == P_DMA);
  assign cpu_err   = cpu_ack && t_err;
  assign dma_err   = dma_ack && t_err;
  assign cpu_rdata = (load_done && t_port == P_CPU) ? load_data : cpu_rdata_q;
  assign dma_rdata = (load_done && t_port == P_DMA) ? load_data : dma_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl with a behavioural
// synchronous RAM and a queue of expected completions.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_zext, dma_req, dma_we, dma_zext;
  logic [1:0]  cpu_size, dma_size;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, cpu_err, dma_ack, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        ram_ena, ram_wena;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] mem [0:255];

  typedef struct {
    bit          port;
    int          ack_cyc;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_cpu_rdata = 32'h0;
  logic [31:0] exp_dma_rdata = 32'h0;

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after a read.
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wena) mem[ram_addr] <= ram_wdata;
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  dmem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_zext(cpu_zext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_zext(dma_zext),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Drive a request at a falling edge; the following rising edge is the end
  // of cycle 0 for that transaction.
  task automatic drive_req(input bit port, input bit we, input logic [1:0] size,
                           input bit zext, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (port) begin
      dma_req = 1'b1; dma_we = we; dma_size = size; dma_zext = zext;
      dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_zext = zext;
      cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Watch cycles 1..20 of a transaction and report what the DUT did.
  task automatic run_txn(input bit port, output int ack_cyc, output int ena_cyc,
                         output int wr_cyc, output logic [31:0] wr_data,
                         output logic [31:0] rd, output logic er);
    ack_cyc = -1; ena_cyc = -1; wr_cyc = -1; wr_data = '0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_ena && ena_cyc < 0) ena_cyc = k;
      if (ram_ena && ram_wena) begin wr_cyc = k; wr_data = ram_wdata; end
      if (port ? dma_ack : cpu_ack) begin
        ack_cyc = k;
        rd = port ? dma_rdata : cpu_rdata;
        er = port ? dma_err : cpu_err;
        break;
      end
    end
    if (port) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_ack, dma_ack, cpu_err, dma_err, ram_ena, ram_wena} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_ctl: got %b expected 000000",
                      {cpu_ack, dma_ack, cpu_err, dma_err, ram_ena, ram_wena});
    end
    total++;
    if ({ram_addr, cpu_rdata, dma_rdata} !== 72'h0) begin
      bad++; $display("[TB] FAIL reset_data: addr=%h cpu_rdata=%h dma_rdata=%h expected 0",
                      ram_addr, cpu_rdata, dma_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    mem[5] = 32'h8899AABB;
    exp_q.push_back('{port: 1'b0, ack_cyc: 2, rdata: 32'h8899AABB, err: 1'b0});
    exp_cpu_rdata = 32'h8899AABB;
    drive_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    run_txn(1'b0, ack_c, ena_c, wr_c, wd, rd, er);
    e = exp_q.pop_front();
    total++;
    if (ena_c !== 1 || wr_c !== -1) begin
      bad++; $display("[TB] FAIL word_load_ram: ena_cyc=%0d wr_cyc=%0d expected 1 and -1", ena_c, wr_c);
    end
    total++;
    if (ack_c !== e.ack_cyc || rd !== e.rdata || er !== e.err) begin
      bad++; $display("[TB] FAIL word_load_ack: cyc=%0d rdata=%h err=%b expected %0d %h %b",
                      ack_c, rd, er, e.ack_cyc, e.rdata, e.err);
    end
    @(negedge clk);
    total++;
    if (cpu_rdata !== exp_cpu_rdata) begin
      bad++; $display("[TB] FAIL word_load_hold: got %h expected %h", cpu_rdata, exp_cpu_rdata);
    end
  endtask

  task automatic test_byte_store();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    mem[2] = 32'h11223344;
    exp_q.push_back('{port: 1'b0, ack_cyc: 3, rdata: exp_cpu_rdata, err: 1'b0});
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h000000EE);
    run_txn(1'b0, ack_c, ena_c, wr_c, wd, rd, er);
    e = exp_q.pop_front();
    total++;
    if (ena_c !== 1 || wr_c !== 2 || wd !== 32'h11EE3344) begin
      bad++; $display("[TB] FAIL byte_store_rmw: rd_cyc=%0d wr_cyc=%0d wdata=%h expected 1 2 11ee3344",
                      ena_c, wr_c, wd);
    end
    total++;
    if (ack_c !== e.ack_cyc || er !== e.err || rd !== e.rdata) begin
      bad++; $display("[TB] FAIL byte_store_ack: cyc=%0d err=%b rdata=%h expected %0d %b %h",
                      ack_c, er, rd, e.ack_cyc, e.err, e.rdata);
    end
    total++;
    if (mem[2] !== 32'h11EE3344) begin
      bad++; $display("[TB] FAIL byte_store_mem: got %h expected 11ee3344", mem[2]);
    end
  endtask

  task automatic test_ext_loads();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b10};
    bit          zx [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4]  = '{32'h0A, 32'h0A, 32'h0A, 32'h08};
    logic [31:0] ex [4]  = '{32'hFFFFFFEE, 32'h000000EE, 32'h000011EE, 32'h11EE3344};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{port: 1'b0, ack_cyc: 2, rdata: ex[i], err: 1'b0});
      exp_cpu_rdata = ex[i];
      drive_req(1'b0, 1'b0, sz[i], zx[i], ad[i], 32'h0);
      run_txn(1'b0, ack_c, ena_c, wr_c, wd, rd, er);
      e = exp_q.pop_front();
      total++;
      if (ack_c !== e.ack_cyc || rd !== e.rdata || er !== e.err) begin
        bad++; $display("[TB] FAIL ext_load_%0d: cyc=%0d rdata=%h err=%b expected %0d %h %b",
                        i, ack_c, rd, er, e.ack_cyc, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_word_store_wrap();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    mem[8] = 32'h0;
    exp_q.push_back('{port: 1'b1, ack_cyc: 2, rdata: exp_dma_rdata, err: 1'b0});
    drive_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0420, 32'hCAFE_F00D);
    run_txn(1'b1, ack_c, ena_c, wr_c, wd, rd, er);
    e = exp_q.pop_front();
    total++;
    if (ena_c !== 1 || wr_c !== 1 || ack_c !== e.ack_cyc || er !== e.err) begin
      bad++; $display("[TB] FAIL word_store: ena=%0d wr=%0d ack=%0d err=%b expected 1 1 %0d %b",
                      ena_c, wr_c, ack_c, er, e.ack_cyc, e.err);
    end
    total++;
    if (mem[8] !== 32'hCAFE_F00D) begin
      bad++; $display("[TB] FAIL word_store_wrap_mem: got %h expected cafef00d", mem[8]);
    end
  endtask

  task automatic test_misaligned();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    bit          pt [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad [3] = '{32'h03, 32'h16, 32'h10};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{port: pt[i], ack_cyc: 1, rdata: pt[i] ? exp_dma_rdata : exp_cpu_rdata, err: 1'b1});
      drive_req(pt[i], 1'b0, sz[i], 1'b0, ad[i], 32'h0);
      run_txn(pt[i], ack_c, ena_c, wr_c, wd, rd, er);
      e = exp_q.pop_front();
      total++;
      if (ack_c !== e.ack_cyc || er !== e.err || ena_c !== -1) begin
        bad++; $display("[TB] FAIL misaligned_%0d: ack=%0d err=%b ena_cyc=%0d expected %0d %b -1",
                        i, ack_c, er, ena_c, e.ack_cyc, e.err);
      end
      total++;
      if (rd !== e.rdata) begin
        bad++; $display("[TB] FAIL misaligned_hold_%0d: rdata=%h expected %h", i, rd, e.rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   seen = 0;
    bit   port;
    pulse_reset();
    mem[16] = 32'hA5A5_0001;
    mem[17] = 32'h5A5A_0002;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{port: i[0], ack_cyc: 2 + 3 * i,
                        rdata: i[0] ? 32'h5A5A_0002 : 32'hA5A5_0001, err: 1'b0});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_zext = 1'b0; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b10; dma_zext = 1'b0; dma_addr = 32'h44;
    for (int k = 1; k <= 30 && seen < 4; k++) begin
      @(negedge clk);
      if (cpu_ack && dma_ack) begin
        total++; bad++; $display("[TB] FAIL b2b_dual_ack: both acks at cycle %0d", k);
      end
      if ((cpu_ack || dma_ack) && exp_q.size() > 0) begin
        port = dma_ack;
        e = exp_q.pop_front();
        seen++;
        total++;
        if (port !== e.port || k !== e.ack_cyc ||
            (port ? dma_rdata : cpu_rdata) !== e.rdata) begin
          bad++; $display("[TB] FAIL b2b_grant_%0d: port=%0d cyc=%0d rdata=%h expected %0d %0d %h",
                          seen, port, k, port ? dma_rdata : cpu_rdata, e.port, e.ack_cyc, e.rdata);
        end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    exp_cpu_rdata = 32'hA5A5_0001; exp_dma_rdata = 32'h5A5A_0002;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("[TB] FAIL b2b_timeout: %0d completions missing", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_rmw();
    int ack_c, ena_c, wr_c; logic [31:0] wd, rd; logic er; exp_t e;
    bit saw_ack = 1'b0;
    mem[2] = 32'h11EE3344;
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h00000055);
    @(negedge clk);
    total++;
    if (ram_ena !== 1'b1 || ram_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL rmw_in_rd: ena=%b wena=%b expected 1 0", ram_ena, ram_wena);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_ack, dma_ack, cpu_err, dma_err, ram_ena, ram_wena} !== 6'b0 ||
        ram_addr !== 8'h0 || cpu_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL rmw_reset_outputs: ctl=%b addr=%h rdata=%h expected 0",
                      {cpu_ack, dma_ack, cpu_err, dma_err, ram_ena, ram_wena}, ram_addr, cpu_rdata);
    end
    cpu_req = 1'b0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) saw_ack = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) saw_ack = 1'b1;
    end
    total++;
    if (saw_ack !== 1'b0 || mem[2] !== 32'h11EE3344) begin
      bad++; $display("[TB] FAIL rmw_reset_lost: ack_seen=%b mem=%h expected 0 11ee3344", saw_ack, mem[2]);
    end
    exp_q.push_back('{port: 1'b0, ack_cyc: 3, rdata: exp_cpu_rdata, err: 1'b0});
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h00000055);
    run_txn(1'b0, ack_c, ena_c, wr_c, wd, rd, er);
    e = exp_q.pop_front();
    total++;
    if (ack_c !== e.ack_cyc || wr_c !== 2 || wd !== 32'h11553344 || er !== e.err) begin
      bad++; $display("[TB] FAIL rmw_after_reset: ack=%0d wr=%0d wdata=%h err=%b expected %0d 2 11553344 %b",
                      ack_c, wr_c, wd, er, e.ack_cyc, e.err);
    end
    total++;
    if (mem[2] !== 32'h11553344) begin
      bad++; $display("[TB] FAIL rmw_after_reset_mem: got %h expected 11553344", mem[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_zext = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_size = 2'b00; dma_zext = 1'b0;
    dma_addr = 32'h0; dma_wdata = 32'h0;
    $display("[TB] starting dmem_ctrl bench");
    test_reset();
    test_word_load();
    test_byte_store();
    test_ext_loads();
    test_word_store_wrap();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
